// File: rtl/mt9v032_pkg.sv
// -----------------------------------------------------------------------------
// mt9v032_pkg
//
// Shared definitions for the MT9V032-class embedded-sync decoder:
//   - state_t    : decoder FSM states
//   - CODE_*     : reserved low-valued sync codes (width independent)
//   - ERR_*      : bit positions inside the err output vector
//   - all1()     : the all-ones reserved code for a given sample width
// -----------------------------------------------------------------------------
package mt9v032_pkg;

  typedef enum logic [2:0] {
    IDLE,   // waiting for the frame-start sequence
    SEQ1,   // seen ALL1
    SEQ2,   // seen ALL1, 0
    FRAME,  // inside a frame, between lines
    LINE    // inside a line, pixels are visible
  } state_t;

  // Reserved codes. The frame-start sequence additionally uses 0 and ALL1.
  localparam int CODE_LS   = 1;  // line start
  localparam int CODE_LE   = 2;  // line end
  localparam int CODE_FE   = 3;  // frame end
  localparam int CODE_ZERO = 4;  // stands in for pixel value 0

  // err[] bit positions.
  localparam int ERR_LEN    = 0;  // wrong pixel count at line end
  localparam int ERR_HEIGHT = 1;  // wrong line count at frame end
  localparam int ERR_CODE   = 2;  // code not legal in the current state

  // All-ones value of a w-bit sample, returned in a 32-bit container so the
  // caller can size it with a cast.
  function automatic logic [31:0] all1(input int w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/mt9v032_frame_check.sv
// -----------------------------------------------------------------------------
// mt9v032_frame_check
//
// Column/row bookkeeping for the sync decoder. Holds the running pixel count
// of the current line and the number of completed lines of the current
// frame, both saturating at 2^CNT_W-1, and compares them against the
// expected geometry. The comparison outputs are combinational views of the
// counters as they stand before the current sample is applied; the caller
// decides when to sample them.
//
// Ports
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   col_clear         start of a line (or line restart): column count -> 0
//   col_step          one visible pixel accepted: column count +1 (saturating)
//   row_clear         start of a frame: completed-line count -> 0
//   row_step          line closed inside a frame: line count +1 (saturating)
//   col               pixel index the next visible pixel will carry
//   row               completed lines so far = row index of the current line
//   len_bad           col != EXP_WIDTH (always 0 when EXP_WIDTH == 0)
//   height_bad_frame  row != EXP_HEIGHT, frame closed between lines
//   height_bad_line   row+1 != EXP_HEIGHT, frame closed while a line is open
//                     (that open line counts toward the height)
// -----------------------------------------------------------------------------
module mt9v032_frame_check #(
  parameter int CNT_W      = 11,
  parameter int EXP_WIDTH  = 752,
  parameter int EXP_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             col_clear,
  input  logic             col_step,
  input  logic             row_clear,
  input  logic             row_step,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             len_bad,
  output logic             height_bad_frame,
  output logic             height_bad_line
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] EXP_W_CNT = CNT_W'(EXP_WIDTH);
  localparam logic [CNT_W-1:0] EXP_H_CNT = CNT_W'(EXP_HEIGHT);
  localparam bit               CHK_W     = (EXP_WIDTH != 0);
  localparam bit               CHK_H     = (EXP_HEIGHT != 0);

  // Counters stick at full scale instead of wrapping, so an overlong line or
  // frame still reads as "too big" in the checks below.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] row_plus;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values from before this clock edge regardless of
  // the order the always blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else begin
      if (col_clear)     col <= '0;
      else if (col_step) col <= sat_inc(col);

      if (row_clear)     row <= '0;
      else if (row_step) row <= sat_inc(row);
    end
  end

  assign row_plus         = sat_inc(row);
  assign len_bad          = CHK_W && (col != EXP_W_CNT);
  assign height_bad_frame = CHK_H && (row != EXP_H_CNT);
  assign height_bad_line  = CHK_H && (row_plus != EXP_H_CNT);

endmodule

// File: rtl/mt9v032_sync_decode.sv
// -----------------------------------------------------------------------------
// mt9v032_sync_decode
//
// Embedded-sync decoder for MT9V032-class pixel streams of configurable
// sample width. Recovers frame/line framing from reserved codes, remaps the
// reserved zero code back to pixel value 0, tags every visible pixel with its
// column/row and emits start/end markers plus framing-error pulses. Every
// output is a flop: a sample seen at clock edge N is visible on the outputs
// right after that same edge and stays there for one cycle.
//
// Stream grammar (ALL1 = 2^DATA_W-1):
//   ALL1, 0, ALL1  frame start (only recognised outside a frame)
//   1 / 2 / 3      line start / line end / frame end
//   4              visible pixel with value 0
//   other          visible pixel (inside a line), ignored elsewhere
//
// Ports
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   data_in      raw sample from the deserialiser
//   px           decoded pixel, 0 unless px_valid
//   px_valid     px carries a visible pixel
//   px_x, px_y   column / row of px (0 when px_valid is low)
//   sof          with the first visible pixel of a frame
//   eol, eof     line end / frame end pulses (coincide on frame end in a line)
//   line_valid   decoder is inside a line
//   frame_valid  decoder is inside a frame
//   err          pulses: [0] line length, [1] frame height, [2] illegal code
// -----------------------------------------------------------------------------
module mt9v032_sync_decode
  import mt9v032_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int CNT_W      = 11,
  parameter int EXP_WIDTH  = 752,
  parameter int EXP_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] px,
  output logic              px_valid,
  output logic [CNT_W-1:0]  px_x,
  output logic [CNT_W-1:0]  px_y,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              line_valid,
  output logic              frame_valid,
  output logic [2:0]        err
);

  localparam logic [DATA_W-1:0] ALL1 = DATA_W'(all1(DATA_W));

  state_t state;
  logic   sof_armed;  // frame started, first visible pixel not yet emitted

  // Sample classification.
  logic is_all1, is_zero, is_ls, is_le, is_fe, is_czero, is_pixel;

  assign is_all1  = (data_in == ALL1);
  assign is_zero  = (data_in == '0);
  assign is_ls    = (data_in == DATA_W'(CODE_LS));
  assign is_le    = (data_in == DATA_W'(CODE_LE));
  assign is_fe    = (data_in == DATA_W'(CODE_FE));
  assign is_czero = (data_in == DATA_W'(CODE_ZERO));
  // Inside a line only 0..3 are codes; 4 and ALL1 are ordinary pixels there.
  assign is_pixel = !(is_zero || is_ls || is_le || is_fe);

  // ---------------------------------------------------------------------------
  // Geometry counters and checks
  // ---------------------------------------------------------------------------
  logic             col_clear, col_step, row_clear, row_step;
  logic [CNT_W-1:0] col, row;
  logic             len_bad, height_bad_frame, height_bad_line;

  assign row_clear = (state == SEQ2) && is_all1;
  // A line start inside a line restarts the column count but keeps the row.
  assign col_clear = ((state == FRAME) || (state == LINE)) && is_ls;
  assign col_step  = (state == LINE) && is_pixel;
  // Only a plain line end advances the row; after a frame end the counter is
  // cleared by the next frame start before it is used again.
  assign row_step  = (state == LINE) && is_le;

  mt9v032_frame_check #(
    .CNT_W      (CNT_W),
    .EXP_WIDTH  (EXP_WIDTH),
    .EXP_HEIGHT (EXP_HEIGHT)
  ) u_frame_check (
    .clk              (clk),
    .rst_n            (rst_n),
    .col_clear        (col_clear),
    .col_step         (col_step),
    .row_clear        (row_clear),
    .row_step         (row_step),
    .col              (col),
    .row              (row),
    .len_bad          (len_bad),
    .height_bad_frame (height_bad_frame),
    .height_bad_line  (height_bad_line)
  );

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sof_armed   <= 1'b0;
      px          <= '0;
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      eof         <= 1'b0;
      line_valid  <= 1'b0;
      frame_valid <= 1'b0;
      err         <= '0;
    end else begin
      // Pulse outputs and the pixel bus default to idle every cycle;
      // line_valid / frame_valid hold and change only on state transitions.
      px       <= '0;
      px_valid <= 1'b0;
      px_x     <= '0;
      px_y     <= '0;
      sof      <= 1'b0;
      eol      <= 1'b0;
      eof      <= 1'b0;
      err      <= '0;

      case (state)
        IDLE: begin
          if (is_all1) state <= SEQ1;
        end

        SEQ1: begin
          // A run of ALL1 keeps the sequence alive.
          if (is_zero)       state <= SEQ2;
          else if (!is_all1) state <= IDLE;
        end

        SEQ2: begin
          if (is_all1) begin
            state       <= FRAME;
            frame_valid <= 1'b1;
            sof_armed   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        FRAME: begin
          if (is_ls) begin
            state      <= LINE;
            line_valid <= 1'b1;
          end else if (is_fe) begin
            state           <= IDLE;
            frame_valid     <= 1'b0;
            eof             <= 1'b1;
            err[ERR_HEIGHT] <= height_bad_frame;
            sof_armed       <= 1'b0;
          end else if (is_le || is_zero) begin
            err[ERR_CODE] <= 1'b1;
          end
        end

        LINE: begin
          if (is_le) begin
            state        <= FRAME;
            line_valid   <= 1'b0;
            eol          <= 1'b1;
            err[ERR_LEN] <= len_bad;
          end else if (is_fe) begin
            state           <= IDLE;
            line_valid      <= 1'b0;
            frame_valid     <= 1'b0;
            eol             <= 1'b1;
            eof             <= 1'b1;
            err[ERR_LEN]    <= len_bad;
            err[ERR_HEIGHT] <= height_bad_line;
            sof_armed       <= 1'b0;
          end else if (is_ls || is_zero) begin
            // Restart (code 1) or drop (code 0); counters handle the restart.
            err[ERR_CODE] <= 1'b1;
          end else begin
            px_valid  <= 1'b1;
            px        <= is_czero ? '0 : data_in;
            px_x      <= col;
            px_y      <= row;
            sof       <= sof_armed;
            sof_armed <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
